event_serializer: RTL and testbench
===================================

# event_serializer

Downstream neighbour of the event filter: it buffers filtered DVS events (x, y, t, polarity) in a small FIFO. It then streams each event off-chip as a fixed 7-byte frame on an 8-bit valid/ready byte interface. It absorbs output-side stalls without back-pressuring the filter, because the filter has no ready input. Events arriving while the FIFO is full are dropped and counted.

## Interface
- DEPTH, 4: FIFO depth in events; power of two, 2..16.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  event present on x/y/t/p this cycle.
- x  in  16  event column.
- y  in  16  event row.
- t  in  16  event timestamp.
- p  in  1  event polarity.
- byte_out  out  8  current frame byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  consumer accepts byte_out this cycle.
- byte_last  out  1  byte_out is byte 6 of a frame.
- fifo_level  out  $clog2(DEPTH)+1  number of events stored.
- drop_count  out  8  saturating count of dropped events.

## Operation
- Push:
  - in_valid=1 and FIFO not full: store {p,x,y,t} (49 bits).
  - in_valid=1 and FIFO full: discard the event and increment drop_count; drop_count saturates at 255.
- Frame layout, MSB first:
  - byte0 = {4'hA, 3'b000, p}
  - byte1 = x[15:8], byte2 = x[7:0]
  - byte3 = y[15:8], byte4 = y[7:0]
  - byte5 = t[15:8], byte6 = t[7:0]
- FSM states:
  - IDLE: byte_valid=0. If the FIFO is non-empty, load the head into the 49-bit frame register, pop, set idx=0 and go to SEND.
  - SEND: byte_valid=1 and byte_out=frame byte[idx]. On a handshake (byte_valid and byte_ready) with idx<6, increment idx. On a handshake with idx=6: if the FIFO is non-empty, load the next event, pop, set idx=0 and stay in SEND; otherwise go to IDLE.
- byte_last = (state==SEND && idx==6).
- Pop happens at load time, so a frame in flight does not occupy a FIFO slot.
- Same-cycle push and pop:
  - Both happen; fifo_level is unchanged.
  - When full, a push coinciding with a pop is accepted, not dropped. The pop is evaluated first.
- Reset (asynchronous, any time, including mid-frame) sets:
  - state=IDLE, idx=0, FIFO empty, frame register=0
  - byte_out=0, byte_valid=0, byte_last=0, fifo_level=0, drop_count=0
- A partially sent frame is abandoned on reset; no resumption.

## Timing
- byte_out, byte_valid and byte_last are registered. No combinational path from byte_ready to byte_out or byte_valid.
- Stability: while byte_valid=1 and byte_ready=0, byte_out and byte_last hold their values.
- Latency, idle block with empty FIFO:
  - in_valid at cycle N is written at edge N.
  - The load happens at edge N+1.
  - byte0 is presented with byte_valid=1 in cycle N+2.
- Throughput: with byte_ready held at 1, one byte per cycle. Back-to-back frames have no bubble: byte0 of the next frame follows byte6 in the next cycle.
- fifo_level updates the cycle after the push or pop edge.
- drop_count increments the cycle after the dropping edge.

## Structure
- Package event_pkg holds:
  - EVT_W = 49
  - FRAME_BYTES = 7
  - SYNC_NIBBLE = 4'hA
  - FSM state enum {IDLE, SEND}
  - packed event typedef {p, x, y, t}
- Sub-module event_fifo: synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: clk, rst, push, pop, din, dout, full, empty, level.
  - dout is the head (first-word fall-through).
  - Pointers are ($clog2(DEPTH)+1)-bit wrap-around pointers; full/empty come from the MSB comparison.
- Top: FSM, idx counter (3 bits), frame register, drop counter, byte mux.

## Test plan
- Single event: x=16'h1234, y=16'h0056, t=16'hBEEF, p=1, byte_ready=1.
  - Required bytes: A1, 12, 34, 00, 56, BE, EF.
  - byte_last only on EF; byte_valid first high 2 cycles after in_valid.
- Stall:
  - Hold byte_ready=0 for 5 cycles at byte3 → byte_out stays 00, byte_valid stays 1.
  - Release → 56 follows.
- Overflow: DEPTH=4, byte_ready=0, push 6 events on consecutive cycles.
  - The first loads into the frame register; the next 4 fill the FIFO; the 6th is dropped.
  - Required: fifo_level=4, drop_count=1.
- Full with same-cycle pop: FIFO full, in_valid coincides with the byte6 handshake → event accepted, drop_count unchanged, fifo_level stays 4.
- Back-to-back: 3 queued events, byte_ready=1 → 21 consecutive valid bytes with byte_last every 7th, no gaps.
- Reset mid-frame:
  - Assert rst during byte2 → all outputs 0 immediately, FIFO empty.
  - After release, a new event produces a full frame starting A0 or A1.
- Saturation: drop 300 events → drop_count=255.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and constants for the DVS event serializer: event layout,
// frame geometry and the byte-select helper used by the output mux.
package event_pkg;

    localparam int           EVT_W       = 49;
    localparam int           FRAME_BYTES = 7;
    localparam logic [3:0]   SYNC_NIBBLE = 4'hA;

    localparam logic [0:0]   ST_IDLE = 1'b0;
    localparam logic [0:0]   ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } state_e;

    typedef struct packed {
        logic        p;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
    } event_t;

    // Byte idx of the 7-byte frame, most significant field first.
    function automatic logic [7:0] frame_byte(input event_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {SYNC_NIBBLE, 3'b000, e.p};
            3'd1:    b = e.x[15:8];
            3'd2:    b = e.x[7:0];
            3'd3:    b = e.y[15:8];
            3'd4:    b = e.y[7:0];
            3'd5:    b = e.t[15:8];
            default: b = e.t[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/event_serializer_if.sv
// Event input bundle plus the byte-stream valid/ready output bundle.
interface event_serializer_if;
    logic        in_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    logic        p;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;

    modport master (
        output in_valid, x, y, t, p, byte_ready,
        input  byte_out, byte_valid, byte_last
    );

    modport slave (
        input  in_valid, x, y, t, p, byte_ready,
        output byte_out, byte_valid, byte_last
    );
endinterface

// File: rtl/event_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // A pop frees the head slot in the same edge, so a push into a full FIFO is legal then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/event_serializer.sv
// Buffers filtered DVS events and streams each one as a 7-byte frame on a
// registered valid/ready byte port; events arriving while full are dropped.
module event_serializer
    import event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    event_serializer_if.slave      evt_if,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_count
);
    event_t                in_evt, head_evt;
    logic [EVT_W-1:0]      fifo_dout;
    logic                  fifo_full, fifo_empty;
    logic                  pop, push, drop;

    state_e                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    event_t                frame_q, frame_d;
    logic [7:0]            drop_q, drop_d;
    logic [7:0]            byte_out_q, byte_out_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;

    assign in_evt   = '{p: evt_if.p, x: evt_if.x, y: evt_if.y, t: evt_if.t};
    assign head_evt = event_t'(fifo_dout);

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_evt),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    frame_d = head_evt;
                    pop     = 1'b1;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (evt_if.byte_ready) begin
                    if (idx_q != 3'(FRAME_BYTES - 1)) begin
                        idx_d = idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        frame_d = head_evt;
                        pop     = 1'b1;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop decided above is what lets a full FIFO still accept this cycle's event.
    assign push   = evt_if.in_valid && (!fifo_full || pop);
    assign drop   = evt_if.in_valid && fifo_full && !pop;
    assign drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    // Outputs are computed from next state so the registered byte lines up with idx.
    assign valid_d    = (state_d == SEND);
    assign last_d     = valid_d && (idx_d == 3'(FRAME_BYTES - 1));
    assign byte_out_d = valid_d ? frame_byte(frame_d, idx_d) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            frame_q    <= '0;
            drop_q     <= 8'h00;
            byte_out_q <= 8'h00;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            drop_q     <= drop_d;
            byte_out_q <= byte_out_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign evt_if.byte_out   = byte_out_q;
    assign evt_if.byte_valid = valid_q;
    assign evt_if.byte_last  = last_q;
    assign drop_count        = drop_q;

endmodule

// File: tb/tb_event_serializer.sv
// Self-checking bench for event_serializer: directed scenarios plus random
// traffic compared against a queue-based model of the event/frame flow.
module tb_event_serializer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] fifo_level;
    logic [7:0] drop_count;
    int         tests = 0;
    int         fails = 0;

    event_serializer_if bus();

    event_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_if     (bus.slave),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
        $fatal(1, "watchdog");
    end

    // Model: stored events, bytes still to be sent of the current frame, drop count.
    logic [48:0] evt_q[$];
    logic [7:0]  cur_q[$];
    int          m_drops;

    task automatic model_reset();
        evt_q.delete();
        cur_q.delete();
        m_drops = 0;
    endtask

    task automatic load_frame(input logic [48:0] e);
        cur_q.push_back(8'hA0 | {7'd0, e[48]});
        cur_q.push_back(e[47:40]);
        cur_q.push_back(e[39:32]);
        cur_q.push_back(e[31:24]);
        cur_q.push_back(e[23:16]);
        cur_q.push_back(e[15:8]);
        cur_q.push_back(e[7:0]);
    endtask

    function automatic logic [48:0] rand_evt();
        return {1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    function automatic logic m_valid();
        return cur_q.size() != 0;
    endfunction

    function automatic logic m_last();
        return cur_q.size() == 1;
    endfunction

    function automatic logic [7:0] m_byte();
        return (cur_q.size() != 0) ? cur_q[0] : 8'h00;
    endfunction

    // Drive one cycle, advance the model across the edge, return at edge+1.
    task automatic cycle(input logic v, input logic [48:0] e, input logic rdy);
        bit sending;
        bus.in_valid   = v;
        bus.p          = e[48];
        bus.x          = e[47:32];
        bus.y          = e[31:16];
        bus.t          = e[15:0];
        bus.byte_ready = rdy;
        @(posedge clk);
        sending = (cur_q.size() != 0);
        if (sending && rdy) void'(cur_q.pop_front());
        // The frame slot empties -> the oldest stored event moves into it.
        if (cur_q.size() == 0 && evt_q.size() != 0) load_frame(evt_q.pop_front());
        if (v) begin
            if (evt_q.size() < DEPTH) evt_q.push_back(e);
            else if (m_drops < 255) m_drops++;
        end
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.t = '0; bus.p = 1'b0;
        bus.byte_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out, fifo_level, drop_count} !== 20'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%h lvl=%0d drop=%0d, need all zero",
                     bus.byte_valid, bus.byte_last, bus.byte_out, fifo_level, drop_count);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_event();
        logic [48:0] ev;
        logic [7:0]  exp_b [7];
        exp_b = '{8'hA1, 8'h12, 8'h34, 8'h00, 8'h56, 8'hBE, 8'hEF};
        ev = {1'b1, 16'h1234, 16'h0056, 16'hBEEF};
        apply_reset();
        cycle(1'b1, ev, 1'b1);
        tests++;
        if (bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_latency_early: got byte_valid=%b one cycle after push, need 0", bus.byte_valid);
        end
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tests++;
            if ({bus.byte_valid, bus.byte_out, bus.byte_last} !== {1'b1, exp_b[i], (i == 6)}) begin
                fails++;
                $display("FAIL single_byte%0d: got v=%b b=%h l=%b, need v=1 b=%h l=%b",
                         i, bus.byte_valid, bus.byte_out, bus.byte_last, exp_b[i], (i == 6));
            end
            cycle(1'b0, '0, 1'b1);
        end
        tests++;
        if (bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_idle_after: got byte_valid=%b, need 0", bus.byte_valid);
        end
        $display("[TB] test_single_event done");
    endtask

    task automatic test_stall();
        logic [48:0] ev;
        ev = {1'b1, 16'h1234, 16'h0056, 16'hBEEF};
        apply_reset();
        cycle(1'b1, ev, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0);
            tests++;
            if ({bus.byte_valid, bus.byte_out, bus.byte_last} !== {1'b1, 8'h00, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold%0d: got v=%b b=%h l=%b, need v=1 b=00 l=0",
                         i, bus.byte_valid, bus.byte_out, bus.byte_last);
            end
        end
        cycle(1'b0, '0, 1'b1);
        tests++;
        if ({bus.byte_valid, bus.byte_out} !== {1'b1, 8'h56}) begin
            fails++;
            $display("FAIL stall_release: got v=%b b=%h, need v=1 b=56", bus.byte_valid, bus.byte_out);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        $display("[TB] test_stall done");
    endtask

    task automatic test_overflow_and_full_pop();
        apply_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_evt(), 1'b0);
        tests++;
        if (fifo_level !== 3'd4 || drop_count !== 8'd1) begin
            fails++;
            $display("FAIL overflow_counts: got level=%0d drop=%0d, need level=4 drop=1", fifo_level, drop_count);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        tests++;
        if ({bus.byte_valid, bus.byte_last} !== 2'b11) begin
            fails++;
            $display("FAIL fullpop_at_byte6: got v=%b l=%b, need v=1 l=1", bus.byte_valid, bus.byte_last);
        end
        cycle(1'b1, rand_evt(), 1'b1);
        tests++;
        if (fifo_level !== 3'd4 || drop_count !== 8'd1) begin
            fails++;
            $display("FAIL fullpop_accept: got level=%0d drop=%0d, need level=4 drop=1", fifo_level, drop_count);
        end
        tests++;
        if ({bus.byte_valid, bus.byte_out, bus.byte_last} !== {m_valid(), m_byte(), m_last()}) begin
            fails++;
            $display("FAIL fullpop_next_frame: got v=%b b=%h l=%b, need v=%b b=%h l=%b",
                     bus.byte_valid, bus.byte_out, bus.byte_last, m_valid(), m_byte(), m_last());
        end
        for (int k = 0; k < 60 && bus.byte_valid; k++) begin
            cycle(1'b0, '0, 1'b1);
            tests++;
            if ({bus.byte_valid, bus.byte_out, bus.byte_last, fifo_level} !==
                {m_valid(), m_byte(), m_last(), 3'(evt_q.size())}) begin
                fails++;
                $display("FAIL fullpop_drain%0d: got v=%b b=%h l=%b lvl=%0d, need v=%b b=%h l=%b lvl=%0d",
                         k, bus.byte_valid, bus.byte_out, bus.byte_last, fifo_level,
                         m_valid(), m_byte(), m_last(), evt_q.size());
            end
        end
        tests++;
        if (bus.byte_valid !== 1'b0 || fifo_level !== 3'd0) begin
            fails++;
            $display("FAIL fullpop_drain_end: got v=%b lvl=%0d, need v=0 lvl=0", bus.byte_valid, fifo_level);
        end
        $display("[TB] test_overflow_and_full_pop done");
    endtask

    task automatic test_back_to_back();
        int errs;
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_evt(), 1'b0);
        errs = 0;
        for (int i = 0; i < 21; i++) begin
            tests++;
            if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, (i % 7 == 6), m_byte()}) begin
                fails++;
                $display("FAIL b2b_byte%0d: got v=%b l=%b b=%h, need v=1 l=%b b=%h",
                         i, bus.byte_valid, bus.byte_last, bus.byte_out, (i % 7 == 6), m_byte());
            end
            cycle(1'b0, '0, 1'b1);
        end
        tests++;
        if (bus.byte_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got byte_valid=%b after 21 bytes, need 0", bus.byte_valid);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_midframe();
        logic [48:0] e;
        apply_reset();
        cycle(1'b1, rand_evt(), 1'b1);
        cycle(1'b1, rand_evt(), 1'b1);
        cycle(1'b1, rand_evt(), 1'b1);
        cycle(1'b0, '0, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out, fifo_level, drop_count} !== 20'd0) begin
            fails++;
            $display("FAIL midframe_reset: got v=%b l=%b b=%h lvl=%0d drop=%0d, need all zero",
                     bus.byte_valid, bus.byte_last, bus.byte_out, fifo_level, drop_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = rand_evt();
        cycle(1'b1, e, 1'b1);
        cycle(1'b0, '0, 1'b1);
        tests++;
        if ({bus.byte_valid, bus.byte_out} !== {1'b1, 4'hA, 3'b000, e[48]}) begin
            fails++;
            $display("FAIL midframe_restart: got v=%b b=%h, need v=1 b=%h",
                     bus.byte_valid, bus.byte_out, {4'hA, 3'b000, e[48]});
        end
        for (int i = 1; i < 7; i++) begin
            cycle(1'b0, '0, 1'b1);
            tests++;
            if ({bus.byte_valid, bus.byte_out, bus.byte_last} !== {m_valid(), m_byte(), m_last()}) begin
                fails++;
                $display("FAIL midframe_byte%0d: got v=%b b=%h l=%b, need v=%b b=%h l=%b",
                         i, bus.byte_valid, bus.byte_out, bus.byte_last, m_valid(), m_byte(), m_last());
            end
        end
        $display("[TB] test_reset_midframe done");
    endtask

    task automatic test_random();
        logic v, rdy;
        int   frames;
        apply_reset();
        frames = 0;
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 99) < 60);
            if (bus.byte_valid && bus.byte_last && rdy) frames++;
            cycle(v, rand_evt(), rdy);
            tests++;
            if ({bus.byte_valid, bus.byte_last, fifo_level, drop_count} !==
                {m_valid(), m_last(), 3'(evt_q.size()), 8'(m_drops)}) begin
                fails++;
                $display("FAIL random_ctrl%0d: got v=%b l=%b lvl=%0d drop=%0d, need v=%b l=%b lvl=%0d drop=%0d",
                         i, bus.byte_valid, bus.byte_last, fifo_level, drop_count,
                         m_valid(), m_last(), evt_q.size(), m_drops);
            end
            if (m_valid()) begin
                tests++;
                if (bus.byte_out !== m_byte()) begin
                    fails++;
                    $display("FAIL random_byte%0d: got %h, need %h", i, bus.byte_out, m_byte());
                end
            end
        end
        $display("[TB] test_random done, %0d frames sent, %0d drops", frames, m_drops);
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 305; i++) cycle(1'b1, rand_evt(), 1'b0);
        tests++;
        if (drop_count !== 8'd255 || drop_count !== 8'(m_drops)) begin
            fails++;
            $display("FAIL saturation: got drop=%0d, need 255 (model %0d)", drop_count, m_drops);
        end
        tests++;
        if (fifo_level !== 3'd4) begin
            fails++;
            $display("FAIL saturation_level: got level=%0d, need 4", fifo_level);
        end
        $display("[TB] test_saturation done");
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_stall();
        test_overflow_and_full_pop();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
